// File: rtl/sirkit_pkg.sv
// sirkit_pkg: shared types and default parameters for the sirkit solver and checkers.
//   state_t     - solver FSM states
//   DEF_*       - default parameter set
//   idx_width() - index width for a given secret length (minimum 1)
package sirkit_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PROBE = 2'd1,
    EMIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int DEF_FLAG_LEN   = 32;
  localparam int DEF_BYTE_W     = 8;
  localparam int DEF_ORACLE_LAT = 1;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int DEF_IDX_W = idx_width(DEF_FLAG_LEN);

endpackage

// File: rtl/sirkit_solver_if.sv
// sirkit_solver_if: oracle probe bus plus result stream.
//   byte_num/byte_guess  solver -> oracle candidate
//   guess_valid          oracle -> solver hit flag
//   out_valid/out_ready  result handshake; out_idx/out_byte/out_miss payload
// master = solver side, slave = oracle/sink side.
interface sirkit_solver_if
  import sirkit_pkg::*;
#(
  parameter int IDX_W  = DEF_IDX_W,
  parameter int BYTE_W = DEF_BYTE_W
);
  logic [IDX_W-1:0]  byte_num;
  logic [BYTE_W-1:0] byte_guess;
  logic              guess_valid;
  logic              out_valid;
  logic              out_ready;
  logic [IDX_W-1:0]  out_idx;
  logic [BYTE_W-1:0] out_byte;
  logic              out_miss;

  modport master (
    output byte_num, byte_guess, out_valid, out_idx, out_byte, out_miss,
    input  guess_valid, out_ready
  );

  modport slave (
    input  byte_num, byte_guess, out_valid, out_idx, out_byte, out_miss,
    output guess_valid, out_ready
  );
endinterface

// File: rtl/sirkit_solver_probe_timer.sv
// sirkit_probe_timer: counts the ORACLE_LAT-cycle hold window of a candidate.
//   clk, rst  clock / async active-high reset
//   restart   force the window back to its first cycle
//   run       count only while probing
//   sample    one-cycle strobe on the last cycle of the window
module sirkit_probe_timer #(
  parameter int LAT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  input  logic run,
  output logic sample
);
  localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;

  logic [CW-1:0] cnt;

  assign sample = run && (cnt == CW'(LAT - 1));

  // Wraps to 0 on the sample edge so back-to-back candidates need no restart.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    cnt <= '0;
    else if (restart || sample) cnt <= '0;
    else if (run)               cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/sirkit_solver.sv
// sirkit_solver: sweeps every candidate for every byte index against an oracle
// and streams the first hit (or a miss) per index.
//   clk, rst   clock / async active-high reset
//   start      begin a sweep (only honoured in IDLE)
//   busy       high from start acceptance until DONE exits
//   done       one-cycle end-of-sweep pulse
//   any_miss   sticky: some index found no hit
//   bus        oracle probe + result stream (master side)
module sirkit_solver
  import sirkit_pkg::*;
#(
  parameter int FLAG_LEN   = DEF_FLAG_LEN,
  parameter int IDX_W      = idx_width(FLAG_LEN),
  parameter int BYTE_W     = DEF_BYTE_W,
  parameter int ORACLE_LAT = DEF_ORACLE_LAT
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic busy,
  output logic done,
  output logic any_miss,
  sirkit_solver_if.master bus
);
  state_t            state;
  logic [IDX_W-1:0]  idx;
  logic [BYTE_W:0]   guess;      // one spare bit: exhaustion shows as carry-out
  logic [BYTE_W:0]   guess_nxt;
  logic              out_valid;
  logic [BYTE_W-1:0] out_byte;
  logic              out_miss;
  logic              sample;
  logic              restart;
  logic              last_idx;

  assign guess_nxt = guess + 1'b1;
  assign last_idx  = (idx == IDX_W'(FLAG_LEN - 1));
  assign restart   = ((state == IDLE) && start) || ((state == EMIT) && bus.out_ready);

  sirkit_probe_timer #(.LAT(ORACLE_LAT)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .restart (restart),
    .run     (state == PROBE),
    .sample  (sample)
  );

  // Oracle ports and result index come straight from state registers.
  assign bus.byte_num   = idx;
  assign bus.byte_guess = guess[BYTE_W-1:0];
  assign bus.out_idx    = idx;
  assign bus.out_valid  = out_valid;
  assign bus.out_byte   = out_byte;
  assign bus.out_miss   = out_miss;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      guess     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      any_miss  <= 1'b0;
      out_valid <= 1'b0;
      out_byte  <= '0;
      out_miss  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state    <= PROBE;
          idx      <= '0;
          guess    <= '0;
          busy     <= 1'b1;
          any_miss <= 1'b0;
        end
        PROBE: if (sample) begin
          if (bus.guess_valid) begin
            out_byte  <= guess[BYTE_W-1:0];
            out_miss  <= 1'b0;
            out_valid <= 1'b1;
            state     <= EMIT;
          end else if (guess_nxt[BYTE_W]) begin
            out_byte  <= '0;
            out_miss  <= 1'b1;
            any_miss  <= 1'b1;
            out_valid <= 1'b1;
            state     <= EMIT;
          end else begin
            guess <= guess_nxt;
          end
        end
        EMIT: if (bus.out_ready) begin
          out_valid <= 1'b0;
          if (last_idx) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            idx   <= idx + 1'b1;
            guess <= '0;
            state <= PROBE;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sirkit_solver.sv
// tb_sirkit_solver: directed checks of sirkit_solver with a table oracle.
// u_a: 6-byte "DUCTF{", ORACLE_LAT=1; u_b: same secret, ORACLE_LAT=3.
module tb_sirkit_solver;
  import sirkit_pkg::*;

  localparam logic [5:0][7:0] SECRET = {8'h7B, 8'h46, 8'h54, 8'h43, 8'h55, 8'h44};

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start_a = 1'b0, start_b = 1'b0, rdy_a = 1'b1;
  logic busy_a, done_a, miss_a, busy_b, done_b, miss_b;
  int   mode = 0;
  int   checks = 0, errors = 0;

  sirkit_solver_if #(.IDX_W(3), .BYTE_W(8)) ia ();
  sirkit_solver_if #(.IDX_W(3), .BYTE_W(8)) ib ();

  // mode 1: idx 2 never hits; mode 2: idx 0 hits on 0x10 and 0x20 only
  function automatic logic hit(input int m, input logic [2:0] n, input logic [7:0] g);
    if (n > 3'd5) return 1'b0;
    if (m == 1 && n == 3'd2) return 1'b0;
    if (m == 2 && n == 3'd0) return (g == 8'h10) || (g == 8'h20);
    return g == SECRET[n];
  endfunction

  assign ia.guess_valid = hit(mode, ia.byte_num, ia.byte_guess);
  assign ia.out_ready   = rdy_a;
  assign ib.guess_valid = hit(0, ib.byte_num, ib.byte_guess);
  assign ib.out_ready   = 1'b1;

  sirkit_solver #(.FLAG_LEN(6), .BYTE_W(8), .ORACLE_LAT(1)) u_a (
    .clk(clk), .rst(rst), .start(start_a), .busy(busy_a), .done(done_a),
    .any_miss(miss_a), .bus(ia)
  );
  sirkit_solver #(.FLAG_LEN(6), .BYTE_W(8), .ORACLE_LAT(3)) u_b (
    .clk(clk), .rst(rst), .start(start_b), .busy(busy_b), .done(done_b),
    .any_miss(miss_b), .bus(ib)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  int rx_idx [8];
  int rx_byte[8];
  int rx_miss[8];
  int rx_cyc [8];
  int nres, ndone;
  bit over10;

  // Start u_a and record every handshake until one cycle past done.
  task automatic sweep_a(input int budget, input bit poke);
    int c = 0;
    int dc = -1;
    nres = 0; ndone = 0; over10 = 0;
    start_a = 1'b1; tick; start_a = 1'b0;
    while (c < budget) begin
      tick; c++;
      start_a = poke && (c == 100 || c == 300);
      if (busy_a && ia.byte_num == 3'd0 && ia.byte_guess > 8'h10) over10 = 1;
      if (ia.out_valid && rdy_a && nres < 8) begin
        rx_idx[nres] = int'(ia.out_idx); rx_byte[nres] = int'(ia.out_byte);
        rx_miss[nres] = int'(ia.out_miss); rx_cyc[nres] = c;
        nres++;
      end
      if (dc >= 0 && c == dc + 1) begin
        chk("busy_after_done", busy_a, 0);
        chk("done_one_cycle", done_a, 0);
        break;
      end
      if (done_a) begin
        ndone++; dc = c;
        chk("busy_at_done", busy_a, 1);
      end
    end
    start_a = 1'b0;
    if (c >= budget) chk("sweep_timeout", ndone, 1);
  endtask

  task automatic chk_stream(input int miss_idx);
    chk("n_results", nres, 6);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("idx_%0d", i), rx_idx[i], i);
      chk($sformatf("byte_%0d", i), rx_byte[i], (i == miss_idx) ? 0 : int'(SECRET[i]));
      chk($sformatf("miss_%0d", i), rx_miss[i], (i == miss_idx) ? 1 : 0);
    end
    chk("done_pulses", ndone, 1);
  endtask

  initial begin
    int c;
    // reset state
    #2 rst = 1'b1;
    #1;
    chk("rst_a", {busy_a, done_a, miss_a, ia.out_valid, ia.out_miss,
                  ia.byte_num, ia.byte_guess, ia.out_idx, ia.out_byte}, 0);
    chk("rst_b", {busy_b, done_b, ib.out_valid, ib.byte_num, ib.byte_guess}, 0);
    tick; tick;
    rst = 1'b0;
    tick;

    // T1: plain sweep, LAT=1
    mode = 0; rdy_a = 1'b1;
    sweep_a(3000, 0);
    chk_stream(-1);
    chk("first_valid_lat1", rx_cyc[0], 69);
    chk("gap_idx1", rx_cyc[1] - rx_cyc[0], 1 + 8'h55 + 1);
    chk("any_miss_clean", miss_a, 0);
    tick;

    // T2: idx 2 never hits
    mode = 1;
    sweep_a(3000, 0);
    chk_stream(2);
    chk("gap_miss", rx_cyc[2] - rx_cyc[1], 257);
    chk("any_miss_set", miss_a, 1);
    tick;

    // T3: sink stalls 10 cycles on idx 0
    mode = 0; rdy_a = 1'b0;
    start_a = 1'b1; tick; start_a = 1'b0;
    chk("any_miss_cleared", miss_a, 0);
    c = 0;
    while (!ia.out_valid && c < 500) begin tick; c++; end
    chk("stall_first_valid", c, 69);
    for (int k = 0; k < 10; k++) begin
      tick;
      chk("stall_hold", {ia.out_valid, ia.out_idx, ia.out_byte, ia.byte_num, ia.byte_guess},
          {1'b1, 3'd0, 8'h44, 3'd0, 8'h44});
    end
    rdy_a = 1'b1;
    c = 0;
    while (busy_a && c < 3000) begin tick; c++; end
    chk("stall_finish", busy_a, 0);
    tick;

    // T4: two hits on idx 0, lowest wins
    mode = 2;
    sweep_a(3000, 0);
    chk("dual_byte", rx_byte[0], 8'h10);
    chk("dual_cycle", rx_cyc[0], 17);
    chk("dual_no_later", over10, 0);
    chk("dual_idx1", rx_byte[1], 8'h55);
    tick;

    // T5: reset during PROBE of idx 3
    mode = 0;
    start_a = 1'b1; tick; start_a = 1'b0;
    c = 0;
    while (ia.byte_num != 3'd3 && c < 2000) begin tick; c++; end
    chk("reach_idx3", ia.byte_num, 3);
    tick; tick; tick;
    chk("probe_idx3_busy", busy_a, 1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst", {busy_a, done_a, miss_a, ia.out_valid, ia.out_miss,
                      ia.byte_num, ia.byte_guess, ia.out_idx, ia.out_byte}, 0);
    tick;
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick;
      chk("post_rst_idle", {busy_a, done_a, ia.out_valid}, 0);
    end
    sweep_a(3000, 1);
    chk_stream(-1);
    for (int k = 0; k < 3; k++) begin
      tick;
      chk("no_restart", busy_a, 0);
    end

    // T6: LAT=3
    start_b = 1'b1; tick; start_b = 1'b0;
    chk("lat3_g0", {busy_b, ib.byte_guess}, {1'b1, 8'h00});
    tick; tick;
    chk("lat3_hold", ib.byte_guess, 8'h00);
    tick;
    chk("lat3_next", ib.byte_guess, 8'h01);
    c = 3;
    while (!ib.out_valid && c < 2000) begin tick; c++; end
    chk("first_valid_lat3", c, 207);
    chk("lat3_byte", ib.out_byte, 8'h44);
    c = 0;
    while (busy_b && c < 5000) begin tick; c++; end
    chk("lat3_finish", {busy_b, miss_b}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
